// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer.
// Resolves beq from the ALU zero flag and pulses a fetch redirect.
module ex_mem_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int BR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] branch_offset,
  input  logic              is_branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              flush_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd_addr;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
  } beat_t;

  beat_t in_beat;
  beat_t main_q;
  beat_t skid_q;
  logic  main_v;
  logic  skid_v;
  logic  accept;
  logic  emit;
  logic  live;
  logic  keep;
  logic  br_hit;

  assign in_beat = '{
    result:     alu_result,
    store_data: store_data,
    rd_addr:    rd_addr,
    mem_read:   mem_read,
    mem_write:  mem_write,
    reg_write:  reg_write,
    mem_to_reg: mem_to_reg
  };

  assign in_ready = ~skid_v;
  assign accept   = in_valid & in_ready;
  assign emit     = main_v & out_ready;
  // Beats accepted during a redirect pulse are wrong-path.
  assign live     = accept & ~flush_in & ~branch_taken;
  assign keep     = live & ~is_branch;
  assign br_hit   = live & is_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v        <= 1'b0;
      skid_v        <= 1'b0;
      main_q        <= '0;
      skid_q        <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else begin
      branch_taken <= br_hit & alu_zero;
      if (br_hit & alu_zero)
        branch_target <= pc_plus4 + (branch_offset << BR_SHIFT);
      if (flush_in) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end else if (emit | ~main_v) begin
        if (skid_v) begin
          main_q <= skid_q;
          main_v <= 1'b1;
          skid_v <= 1'b0;
        end else begin
          main_v <= keep;
          if (keep)
            main_q <= in_beat;
        end
      end else if (keep) begin
        skid_q <= in_beat;
        skid_v <= 1'b1;
      end
    end
  end

  assign out_valid      = main_v;
  assign out_result     = main_q.result;
  assign out_store_data = main_q.store_data;
  assign out_rd_addr    = main_q.rd_addr;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_to_reg = main_q.mem_to_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic [31:0] pc_plus4;
  logic [31:0] branch_offset;
  logic        is_branch;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        flush_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd_addr;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_reg_write;
  logic        out_mem_to_reg;
  logic        branch_taken;
  logic [31:0] branch_target;

  int vectors = 0;
  int miscompares = 0;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .store_data(store_data), .rd_addr(rd_addr),
    .pc_plus4(pc_plus4), .branch_offset(branch_offset),
    .is_branch(is_branch),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .flush_in(flush_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data),
    .out_rd_addr(out_rd_addr),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] res, input logic [4:0] rd);
    in_valid   = 1'b1;
    is_branch  = 1'b0;
    alu_result = res;
    store_data = ~res;
    rd_addr    = rd;
    reg_write  = 1'b1;
  endtask

  task automatic branch(input logic zero, input logic [31:0] pc,
                        input logic [31:0] off);
    in_valid      = 1'b1;
    is_branch     = 1'b1;
    alu_zero      = zero;
    pc_plus4      = pc;
    branch_offset = off;
    alu_result    = 32'hBAD0_0000;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    is_branch = 1'b0;
    flush_in  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; alu_result = 0; alu_zero = 0; store_data = 0;
    rd_addr = 0; pc_plus4 = 0; branch_offset = 0; is_branch = 0;
    mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0;
    flush_in = 0; out_ready = 1;
    step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_br_taken", 32'(branch_taken), 0);
    chk("rst_result", out_result, 0);
    chk("rst_target", branch_target, 0);
    rst_n = 1'b1;
    step();

    // single beat, 1-cycle latency
    beat(32'h0000_00A5, 5'd5);
    step();
    chk("b1_valid", 32'(out_valid), 1);
    chk("b1_result", out_result, 32'hA5);
    chk("b1_rd", 32'(out_rd_addr), 5);
    chk("b1_rw", 32'(out_reg_write), 1);
    chk("b1_sd", out_store_data, ~32'hA5);

    // 8 back-to-back beats, no bubbles
    for (int i = 0; i < 8; i++) begin
      beat(32'h10 + 32'(i), 5'(i + 1));
      step();
      chk($sformatf("stream%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("stream%0d_res", i), out_result, 32'h10 + 32'(i));
      chk($sformatf("stream%0d_rd", i), 32'(out_rd_addr), 32'(i + 1));
    end
    idle();
    step();
    chk("drain_valid", 32'(out_valid), 0);

    // backpressure: A,B stored, C held off until release
    out_ready = 1'b0;
    beat(32'hA, 5'd10);
    step();
    chk("bp_in_ready_a", 32'(in_ready), 1);
    beat(32'hB, 5'd11);
    step();
    chk("bp_in_ready_b", 32'(in_ready), 0);
    chk("bp_hold_a", out_result, 32'hA);
    beat(32'hC, 5'd12);
    step();
    chk("bp_stable", out_result, 32'hA);
    chk("bp_stable_rd", 32'(out_rd_addr), 10);
    chk("bp_still_full", 32'(in_ready), 0);
    out_ready = 1'b1;
    step();
    chk("bp_out_b", out_result, 32'hB);
    chk("bp_ready_back", 32'(in_ready), 1);
    step();
    chk("bp_out_c", out_result, 32'hC);
    chk("bp_out_c_v", 32'(out_valid), 1);
    idle();
    step();
    chk("bp_no_dup", 32'(out_valid), 0);

    // taken branch, wrong-path beat dropped
    branch(1'b1, 32'h100, 32'hFFFF_FFFC);
    step();
    chk("br_taken", 32'(branch_taken), 1);
    chk("br_target", branch_target, 32'hF0);
    chk("br_no_fwd", 32'(out_valid), 0);
    beat(32'h77, 5'd7);
    step();
    chk("br_pulse_end", 32'(branch_taken), 0);
    chk("br_wrong_path", 32'(out_valid), 0);
    branch(1'b0, 32'h200, 32'h4);
    step();
    chk("nt_no_pulse", 32'(branch_taken), 0);
    chk("nt_target_hold", branch_target, 32'hF0);
    chk("nt_no_fwd", 32'(out_valid), 0);

    // back-to-back branches: second lands in pulse cycle
    branch(1'b1, 32'h400, 32'h8);
    step();
    chk("bb1_taken", 32'(branch_taken), 1);
    chk("bb1_target", branch_target, 32'h420);
    branch(1'b1, 32'h800, 32'h1);
    step();
    chk("bb2_dropped", 32'(branch_taken), 0);
    chk("bb2_target", branch_target, 32'h420);
    branch(1'b1, 32'h800, 32'h1);
    step();
    chk("bb3_taken", 32'(branch_taken), 1);
    chk("bb3_target", branch_target, 32'h804);
    idle();
    step();

    // flush with both entries full
    out_ready = 1'b0;
    beat(32'hF1, 5'd1);
    step();
    beat(32'hF2, 5'd2);
    step();
    chk("fl_full", 32'(in_ready), 0);
    beat(32'hF3, 5'd3);
    flush_in = 1'b1;
    step();
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_ready", 32'(in_ready), 1);
    // flush with main full and an accepted beat
    idle();
    beat(32'hF4, 5'd4);
    step();
    beat(32'hF5, 5'd5);
    flush_in = 1'b1;
    step();
    chk("fl2_valid", 32'(out_valid), 0);
    chk("fl2_ready", 32'(in_ready), 1);
    idle();
    out_ready = 1'b1;
    step();
    chk("fl2_gone", 32'(out_valid), 0);
    // flushed branch gives no pulse
    branch(1'b1, 32'h1000, 32'h10);
    flush_in = 1'b1;
    step();
    chk("fl_br_pulse", 32'(branch_taken), 0);
    chk("fl_br_target", branch_target, 32'h804);
    idle();
    step();

    // async reset mid-stream during a redirect pulse
    out_ready = 1'b0;
    beat(32'h55, 5'd9);
    step();
    branch(1'b1, 32'h40, 32'h0);
    step();
    chk("pre_rst_pulse", 32'(branch_taken), 1);
    chk("pre_rst_valid", 32'(out_valid), 1);
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    chk("mid_rst_pulse", 32'(branch_taken), 0);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_target", branch_target, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
